// File: rtl/serial2tcp_line_buffer.sv
// Line-assembling byte buffer between the serial2tcp source stream and its consumer.
// Bytes are held back until a delimiter, a full buffer or an idle timeout commits
// them, so downstream sees whole lines rather than single-byte bursts.
module serial2tcp_line_buffer #(
  parameter int         DEPTH   = 64,
  parameter logic [7:0] DELIM   = 8'h0A,
  parameter int         TIMEOUT = 1000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic [7:0]               sink_data,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic [7:0]               source_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // A TIMEOUT of 0 or 1 still gets a 1-bit timer so the declarations stay legal.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] committed;
  logic [LW-1:0] level_next;
  logic [LW-1:0] committed_next;
  logic [LW-1:0] commit_base;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          push;
  logic          pop;
  logic          is_delim;
  logic          timeout_fire;

  // Handshake flags depend only on registered state, never on the opposite side.
  assign sink_ready   = (level != FULL_LVL);
  assign source_valid = (committed != '0);
  assign source_data  = mem[rd_ptr];
  assign pending      = (level > committed);

  assign push     = sink_valid & sink_ready;
  assign pop      = source_valid & source_ready;
  assign is_delim = push & (sink_data == DELIM);

  // Occupancy after this edge's push and pop.
  always_comb begin
    level_next = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
  end

  // Idle timer: counts only while uncommitted bytes wait and nothing arrives;
  // it returns to zero on a push, on firing, or when nothing is pending.
  always_comb begin
    timeout_fire = 1'b0;
    timer_next   = '0;
    if ((TIMEOUT > 0) && !push && pending) begin
      if (timer == TIMER_LAST) begin
        timeout_fire = 1'b1;
      end else begin
        timer_next = timer + TW'(1);
      end
    end
  end

  // Commit boundary: delimiter beats full beats timeout; otherwise only pops shrink it.
  always_comb begin
    commit_base    = committed - {{(LW-1){1'b0}}, pop};
    committed_next = commit_base;
    if (is_delim) begin
      committed_next = level_next;
    end else if (level_next == FULL_LVL) begin
      committed_next = FULL_LVL;
    end else if (timeout_fire) begin
      committed_next = level_next;
    end
  end

  // Pointer, occupancy, commit and timer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      committed <= '0;
      timer     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level     <= level_next;
      committed <= committed_next;
      timer     <= timer_next;
    end
  end

  // Byte storage; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= sink_data;
    end
  end

endmodule

// File: tb/tb_serial2tcp_line_buffer.sv
// Self-checking bench for serial2tcp_line_buffer: a stimulus table for the basic
// line release, directed multi-cycle corner cases, then randomized traffic, all
// compared against a queue-based reference model.
module tb_serial2tcp_line_buffer;

  localparam int         DEPTH   = 8;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] DELIM   = 8'h0A;

  logic       sys_clk      = 1'b0;
  logic       sys_rst_n    = 1'b0;
  logic       sink_valid   = 1'b0;
  logic       sink_ready;
  logic [7:0] sink_data    = 8'h00;
  logic       source_valid;
  logic       source_ready = 1'b0;
  logic [7:0] source_data;
  logic [3:0] level;
  logic       pending;

  int total  = 0;
  int passed = 0;

  // Reference model: stored bytes in arrival order, how many of them are
  // released, and edges elapsed since the last accepted byte.
  byte unsigned mq[$];
  int           mcommit    = 0;
  int           since_push = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    int         el;
    logic       ep;
  } vec_t;

  vec_t tbl[7];

  serial2tcp_line_buffer #(
    .DEPTH   (DEPTH),
    .DELIM   (DELIM),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_data    (sink_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .level        (level),
    .pending      (pending)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    mcommit    = 0;
    since_push = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, take the edge,
  // advance the model. Called and returns at a falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit push, pop, pend_before, fire;
    int lvl, base;
    sink_valid   = v;
    sink_data    = d;
    source_ready = r;
    #1;
    chk("sink_ready",   int'(sink_ready),   int'(mq.size() != DEPTH));
    chk("source_valid", int'(source_valid), int'(mcommit != 0));
    chk("level",        int'(level),        mq.size());
    chk("pending",      int'(pending),      int'(mq.size() > mcommit));
    if (mcommit != 0) chk("source_data", int'(source_data), int'(mq[0]));
    push        = v && (mq.size() != DEPTH);
    pop         = r && (mcommit != 0);
    pend_before = mq.size() > mcommit;
    @(posedge sys_clk);
    base = mcommit - (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(d);
      since_push = 0;
    end else begin
      since_push++;
    end
    lvl  = mq.size();
    fire = (TIMEOUT > 0) && !push && pend_before && (since_push == TIMEOUT);
    if (push && d == DELIM)  mcommit = lvl;
    else if (lvl == DEPTH)   mcommit = DEPTH;
    else if (fire)           mcommit = lvl;
    else                     mcommit = base;
    @(negedge sys_clk);
  endtask

  // Pop committed bytes until none remain, bounded.
  task automatic drain(input string name);
    for (int i = 0; i < 40 && mcommit != 0; i++) step(1'b0, 8'h00, 1'b1);
    #1;
    chk(name, int'(source_valid), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h68, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    tbl[1] = '{1'b1, 8'h69, 1'b1, 1'b0, 8'h00, 1, 1'b1};
    tbl[2] = '{1'b1, 8'h0A, 1'b1, 1'b0, 8'h00, 2, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h68, 3, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h69, 2, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    // Reset state
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    chk("rst_source_valid", int'(source_valid), 0);
    chk("rst_sink_ready",   int'(sink_ready),   1);
    chk("rst_level",        int'(level),        0);
    chk("rst_pending",      int'(pending),      0);

    // 1. Line release from the vector table
    for (int i = 0; i < 7; i++) begin
      #0;
      chk("t1_valid",   int'(source_valid), int'(tbl[i].ev));
      if (tbl[i].ev) chk("t1_data", int'(source_data), int'(tbl[i].ed));
      chk("t1_level",   int'(level),   tbl[i].el);
      chk("t1_pending", int'(pending), int'(tbl[i].ep));
      step(tbl[i].v, tbl[i].d, tbl[i].r);
    end

    // 2. Timeout release of a lone byte
    step(1'b1, 8'h41, 1'b1);
    repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b1);
    #1;
    chk("t2_held_valid",   int'(source_valid), 0);
    chk("t2_held_pending", int'(pending),      1);
    step(1'b0, 8'h00, 1'b0);
    #1;
    chk("t2_rel_valid", int'(source_valid), 1);
    chk("t2_rel_data",  int'(source_data),  8'h41);
    drain("t2_drained");

    // 3. Full buffer forces a commit
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    #1;
    chk("t3_full_sink_ready", int'(sink_ready),   0);
    chk("t3_full_valid",      int'(source_valid), 1);
    chk("t3_full_level",      int'(level),        DEPTH);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    drain("t3_drained");

    // 4. Backpressure with new bytes arriving during the drain
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 40 && (i < 2 || mcommit != 0); i++) begin
      logic r;
      r = (i >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      step(i < 2, (i == 0) ? 8'h43 : 8'h44, r);
    end
    #1;
    chk("t4_level",   int'(level),        2);
    chk("t4_pending", int'(pending),      1);
    chk("t4_valid",   int'(source_valid), 0);
    step(1'b1, 8'h0A, 1'b1);
    drain("t4_drained");

    // 5. Pointer wrap-around over several short lines
    for (int l = 0; l < 5; l++) begin
      step(1'b1, 8'h78, 1'b0);
      step(1'b1, 8'h79, 1'b0);
      step(1'b1, 8'h0A, 1'b0);
      drain("t5_drained");
    end

    // 6. Asynchronous reset in the middle of a drain
    for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    source_ready = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",      int'(source_valid), 0);
    chk("t6_rst_level",      int'(level),        0);
    chk("t6_rst_sink_ready", int'(sink_ready),   1);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    #1;
    chk("t6_z_data", int'(source_data), 8'h5A);
    drain("t6_drained");

    // Randomized traffic in phases of differing push and pop pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 250; i++) begin
        logic       v, r;
        logic [7:0] d;
        case (ph)
          0: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
          1: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
          2: begin v = ($urandom_range(0, 19) == 0); r = ($urandom_range(0, 1) == 0); end
          default: begin v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
        endcase
        d = ($urandom_range(0, 5) == 0) ? DELIM : 8'($urandom);
        step(v, d, r);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
